// File: rtl/mips_pkg.sv
// Shared MIPS datapath encodings: next-instruction-select codes and helpers
// used by the control decoder and the PC stage.
package mips_pkg;

    localparam logic [2:0] NIS_SEQ   = 3'b000;
    localparam logic [2:0] NIS_BMV   = 3'b001;
    localparam logic [2:0] NIS_BZ    = 3'b010;
    localparam logic [2:0] NIS_SRLV  = 3'b011;
    localparam logic [2:0] NIS_RSVD  = 3'b100;
    localparam logic [2:0] NIS_BALRN = 3'b101;
    localparam logic [2:0] NIS_JMEM  = 3'b110;
    localparam logic [2:0] NIS_BEQ   = 3'b111;

    localparam logic [4:0] RA_REG = 5'd31;

    // Word branch offset: sign-extend and scale to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_unit_status_flags.sv
// Z/N status flag register; written from the ALU result when enabled.
module status_flags
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        we,
    input  logic [31:0] result,
    output logic        flag_z,
    output logic        flag_n
);

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (!stall && we) begin
            flag_z <= (result == 32'd0);
            flag_n <= result[31];
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// PC stage of the single-cycle MIPS datapath: next-PC select, link request,
// status flags, retired-instruction counter and sticky error bits.
module next_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  nis,
    input  logic [15:0] imm,
    input  logic        alu_zero,
    input  logic [31:0] alu_result,
    input  logic        flag_we,
    input  logic [31:0] rs_data,
    input  logic [31:0] mem_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        taken,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        flag_z,
    output logic        flag_n,
    output logic [31:0] icount,
    output logic        illegal,
    output logic        align_err
);

    logic [31:0] bt;
    logic [31:0] pc_nxt;
    logic        redirect;
    logic        link_req;
    logic        rsvd_hit;
    logic        misalign;

    assign pc_plus4  = pc + 32'd4;
    assign bt        = pc_plus4 + branch_offset(imm);
    assign link_data = pc_plus4;

    // Branch conditions read the flags registered before this edge.
    always_comb begin
        pc_nxt   = pc_plus4;
        redirect = 1'b0;
        link_req = 1'b0;
        rsvd_hit = 1'b0;
        misalign = 1'b0;
        case (nis)
            NIS_BMV: begin
                if (flag_n) begin
                    pc_nxt   = bt;
                    redirect = 1'b1;
                end
            end
            NIS_BZ: begin
                if (flag_z) begin
                    pc_nxt   = bt;
                    redirect = 1'b1;
                end
            end
            NIS_RSVD: rsvd_hit = 1'b1;
            NIS_BALRN: begin
                if (flag_n) begin
                    pc_nxt   = word_align(rs_data);
                    redirect = 1'b1;
                    link_req = 1'b1;
                    misalign = |rs_data[1:0];
                end
            end
            NIS_JMEM: begin
                pc_nxt   = word_align(mem_data);
                redirect = 1'b1;
                misalign = |mem_data[1:0];
            end
            NIS_BEQ: begin
                if (alu_zero) begin
                    pc_nxt   = bt;
                    redirect = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign taken   = redirect;
    assign link_we = link_req & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            icount    <= 32'd0;
            illegal   <= 1'b0;
            align_err <= 1'b0;
        end else if (!stall) begin
            pc        <= pc_nxt;
            icount    <= icount + 32'd1;
            illegal   <= illegal | rsvd_hit;
            align_err <= align_err | misalign;
        end
    end

    status_flags u_flags (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall),
        .we     (flag_we),
        .result (alu_result),
        .flag_z (flag_z),
        .flag_n (flag_n)
    );

endmodule

// File: tb/tb_next_pc_unit.sv
// Randomized and directed bench for next_pc_unit against a behavioural model.
module tb_next_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  nis = 3'd0;
    logic [15:0] imm = 16'd0;
    logic        alu_zero = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic        flag_we = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] mem_data = 32'd0;
    logic [31:0] pc, pc_plus4, link_data, icount;
    logic        taken, link_we, flag_z, flag_n, illegal, align_err;

    next_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .nis        (nis),
        .imm        (imm),
        .alu_zero   (alu_zero),
        .alu_result (alu_result),
        .flag_we    (flag_we),
        .rs_data    (rs_data),
        .mem_data   (mem_data),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .taken      (taken),
        .link_we    (link_we),
        .link_data  (link_data),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .icount     (icount),
        .illegal    (illegal),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [31:0] m_pc, m_icount;
    logic        m_z, m_n, m_ill, m_align;
    bit          m_valid = 0;

    // Values captured at the last sample point, for directed checks
    logic        s_taken, s_link_we;
    logic [31:0] s_link_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst_i, input logic stall_i, input logic [2:0] nis_i,
                         input logic [15:0] imm_i, input logic az_i, input logic [31:0] ar_i,
                         input logic fwe_i, input logic [31:0] rs_i, input logic [31:0] md_i);
        logic [31:0] e_p4, e_bt, e_next;
        logic        e_taken, e_link;
        int          sel;
        @(negedge clk);
        reset = rst_i; stall = stall_i; nis = nis_i; imm = imm_i; alu_zero = az_i;
        alu_result = ar_i; flag_we = fwe_i; rs_data = rs_i; mem_data = md_i;
        #1;
        e_p4 = m_pc + 32'd4;
        e_bt = e_p4 + 32'($signed(imm_i)) * 32'd4;
        sel  = int'(nis_i);
        e_next = e_p4; e_taken = 0; e_link = 0;
        if ((sel == 1 && m_n) || (sel == 2 && m_z) || (sel == 7 && az_i)) begin
            e_next = e_bt; e_taken = 1;
        end else if (sel == 5 && m_n) begin
            e_next = rs_i - (rs_i % 4); e_taken = 1; e_link = 1;
        end else if (sel == 6) begin
            e_next = md_i - (md_i % 4); e_taken = 1;
        end
        s_taken = taken; s_link_we = link_we; s_link_data = link_data;
        if (m_valid) begin
            check("pc", pc, m_pc);
            check("pc_plus4", pc_plus4, e_p4);
            check("taken", 32'(taken), 32'(e_taken));
            check("link_we", 32'(link_we), 32'(e_link && !stall_i));
            check("link_data", link_data, e_p4);
            check("flag_z", 32'(flag_z), 32'(m_z));
            check("flag_n", 32'(flag_n), 32'(m_n));
            check("icount", icount, m_icount);
            check("illegal", 32'(illegal), 32'(m_ill));
            check("align_err", 32'(align_err), 32'(m_align));
        end
        @(posedge clk);
        if (rst_i) begin
            m_pc = RST_PC; m_icount = 0; m_z = 0; m_n = 0; m_ill = 0; m_align = 0;
            m_valid = 1;
        end else if (!stall_i) begin
            if (e_taken && sel != 1 && sel != 2 && sel != 7 && (e_next != (sel == 5 ? rs_i : md_i)))
                m_align = 1;
            if (sel == 4) m_ill = 1;
            if (fwe_i) begin
                m_z = (ar_i == 0);
                m_n = (ar_i >= 32'h8000_0000);
            end
            m_pc = e_next;
            m_icount = m_icount + 1;
        end
        #1;
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 3'd0, 16'd0, 0, 32'd1, 0, 32'd0, 32'd0);
    endtask

    initial begin
        // Reset, then straight-line fetch
        cycle(1, 1, 3'd6, 16'h1234, 1, 32'd0, 1, 32'd7, 32'h100);
        check("rst_pc", pc, RST_PC);
        check("rst_icount", icount, 32'd0);
        check("rst_sticky", {30'd0, illegal, align_err}, 32'd0);
        check("rst_flags", {30'd0, flag_z, flag_n}, 32'd0);
        seq(3);
        check("seq_pc", pc, 32'h0040_000C);
        check("seq_icount", icount, 32'd3);

        // beq with negative offset
        cycle(0, 0, 3'd6, 16'd0, 0, 32'd1, 0, 32'd0, 32'h0000_0010);
        check("jmem_pc", pc, 32'h0000_0010);
        cycle(0, 0, 3'd7, 16'hFFFF, 1, 32'd1, 0, 32'd0, 32'd0);
        check("beq_taken_pc", pc, 32'h0000_0010);
        cycle(0, 0, 3'd7, 16'hFFFF, 0, 32'd1, 0, 32'd0, 32'd0);
        check("beq_nt_pc", pc, 32'h0000_0014);

        // Flag written this cycle only affects the next decision
        cycle(0, 0, 3'd0, 16'd0, 0, 32'd5, 1, 32'd0, 32'd0);
        cycle(0, 0, 3'd2, 16'd8, 0, 32'd0, 1, 32'd0, 32'd0);
        check("bz_same_cycle_taken", 32'(s_taken), 32'd0);
        check("bz_same_cycle_pc", pc, 32'h0000_001C);
        cycle(0, 0, 3'd2, 16'd8, 0, 32'd9, 0, 32'd0, 32'd0);
        check("bz_next_taken", 32'(s_taken), 32'd1);
        check("bz_next_pc", pc, 32'h0000_0040);

        // balrn with misaligned register target
        cycle(0, 0, 3'd6, 16'd0, 0, 32'h8000_0000, 1, 32'd0, 32'h0000_0100);
        cycle(0, 0, 3'd5, 16'd0, 0, 32'd1, 0, 32'h0000_1003, 32'd0);
        check("balrn_link_we", 32'(s_link_we), 32'd1);
        check("balrn_link_data", s_link_data, 32'h0000_0104);
        check("balrn_pc", pc, 32'h0000_1000);
        check("balrn_align", 32'(align_err), 32'd1);

        // Reserved code, sticky illegal
        cycle(0, 0, 3'd4, 16'd0, 0, 32'd1, 0, 32'd0, 32'd0);
        check("rsvd_pc", pc, 32'h0000_1004);
        check("rsvd_illegal", 32'(illegal), 32'd1);
        seq(2);
        check("illegal_sticky", 32'(illegal), 32'd1);

        // Stall holds everything; link_we suppressed
        cycle(0, 1, 3'd6, 16'd0, 0, 32'd0, 1, 32'd0, 32'h0000_2000);
        cycle(0, 1, 3'd5, 16'd0, 0, 32'd0, 1, 32'h0000_3000, 32'h0000_2000);
        check("stall_link_we", 32'(s_link_we), 32'd0);
        check("stall_pc", pc, 32'h0000_100C);
        check("stall_icount", icount, m_icount);

        // PC wraps
        cycle(0, 0, 3'd6, 16'd0, 0, 32'd1, 0, 32'd0, 32'hFFFF_FFFC);
        check("wrap_pre", pc, 32'hFFFF_FFFC);
        seq(1);
        check("wrap_pc", pc, 32'h0000_0000);

        // Reset mid-branch discards redirect
        cycle(1, 0, 3'd6, 16'd0, 0, 32'd1, 0, 32'd0, 32'h0000_5000);
        check("rst_mid_pc", pc, RST_PC);
        check("rst_mid_sticky", {30'd0, illegal, align_err}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ar;
            ar = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                  3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)),
                  ar, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Program-counter stage of the single-cycle MIPS datapath. Holds the PC, the Z/N status flags and a retired-instruction counter. Computes the next PC from the 3-bit next-instruction-select code produced by the main control decoder, plus ALU, register-file and data-memory values. Drives the instruction memory address and the link-register write request for branch-and-link.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- stall  in  1  hold all state this cycle (PC, flags, counter, sticky bits).
- nis  in  3  next-instruction select {nis2,nis1,nis0} from control decoder.
- imm  in  16  instruction immediate (branch offset, words).
- alu_zero  in  1  ALU zero output for the current instruction (beq compare).
- alu_result  in  32  ALU result of current instruction (flag source).
- flag_we  in  1  update Z/N from alu_result at end of cycle.
- rs_data  in  32  register-file rs read value (register jump target).
- mem_data  in  32  data-memory read value (memory jump target).
- pc  out  32  current PC (instruction memory address).
- pc_plus4  out  32  pc + 4, modulo 2^32.
- taken  out  1  combinational: next PC ≠ pc_plus4 selected this cycle.
- link_we  out  1  combinational: request write of link_data to $31.
- link_data  out  32  equals pc_plus4.
- flag_z, flag_n  out  1 each  registered status flags.
- icount  out  32  retired-instruction counter.
- illegal  out  1  sticky: reserved nis code seen.
- align_err  out  1  sticky: register/memory target had nonzero bits [1:0].

## Operation
- Branch target bt = pc_plus4 + (sign-extend(imm) << 2), 32-bit modulo.
- Next-PC selection by nis:
  - 000: pc_plus4.
  - 001 (bmv): bt if flag_n, else pc_plus4.
  - 010 (bz): bt if flag_z, else pc_plus4.
  - 011 (srlv): pc_plus4.
  - 100: reserved. Use pc_plus4 and set illegal.
  - 101 (balrn): {rs_data[31:2],2'b00} if flag_n, else pc_plus4. link_we = flag_n.
  - 110 (jsp/jmadd): {mem_data[31:2],2'b00}, unconditional.
  - 111 (beq): bt if alu_zero, else pc_plus4.
- align_err is set when a register or memory target is *selected* and the source has bits[1:0] ≠ 0. The target is still taken, with the low bits cleared.
- Flags: when flag_we, Z ← (alu_result == 0) and N ← alu_result[31].
- Branch decisions use the flag values registered before this edge. A flag_we in the same cycle affects the next instruction only.
- icount increments by 1 on every non-stalled, non-reset edge and wraps 2^32−1 → 0.
- link_we is forced to 0 while stall = 1.

## Timing
- All state updates on the rising edge of clk. Zero-latency combinational next-PC; the new PC is visible one cycle after the decision.
- Reset (priority over stall):
  - pc = RESET_PC, flag_z = 0, flag_n = 0, icount = 0, illegal = 0, align_err = 0.
  - Combinational outputs then follow from these values.
- Reset mid-branch: the pending redirect is discarded and pc = RESET_PC.
- Stall: every register holds its value; the combinational outputs still reflect current inputs, except link_we = 0.
- Sticky bits clear only on reset.

## Structure
- Shared package mips_pkg:
  - NIS_SEQ, NIS_BMV, NIS_BZ, NIS_SRLV, NIS_RSVD, NIS_BALRN, NIS_JMEM, NIS_BEQ encodings.
  - RA_REG = 5'd31.
  - The control decoder must import the same encodings.
- One sub-module: status_flags (Z/N register with write-enable, stall, reset).
- PC mux, adders and counter stay inline.

## Test plan
- Reset with RESET_PC = 32'h0040_0000, then 3 cycles with nis = 000 -> pc = 0040_0000, 0040_0004, 0040_0008; icount = 3.
- pc = 0000_0010, nis = 111, imm = 16'hFFFF, alu_zero = 1 -> next pc = 0000_0010; with alu_zero = 0 -> 0000_0014.
- flag_we with alu_result = 0 in cycle n, nis = 010 in the same cycle -> not taken; nis = 010 in cycle n+1 -> taken to bt.
- flag_n = 1, nis = 101, rs_data = 0000_1003, pc = 0000_0100 -> link_we = 1, link_data = 0000_0104, next pc = 0000_1000, align_err = 1.
- nis = 100 -> pc advances by 4 and illegal = 1; illegal stays 1 until reset.
- stall = 1 for 2 cycles with nis = 110 -> pc, icount and flags are unchanged and link_we = 0; pc reaches 0xFFFF_FFFC then nis = 000 -> pc = 0000_0000.
